// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch stage.
package fetch_pkg;

   localparam int          XLEN_DEF = 32;
   localparam logic [31:0] INST_NOP = 32'h0000_0013;  // addi x0, x0, 0

   // Fetch sequencer: issue a request, wait for its data, or throw away
   // the data of a request that a redirect has made stale.
   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAIN = 2'd2
   } fq_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {instruction, pc+4} pairs for decode.
// Flush wins over push and pop; the head is read straight from storage.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // Entry storage write port.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; count gates its visibility, so it maps to plain RAM.
      if (push && !flush) mem[wr_ptr] <= wdata;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch stage: owns the fetch PC, keeps at most one
// request outstanding to instruction memory, buffers returned words with
// their pc+4 and hands them to decode. A taken branch flushes everything
// queued, squashes the in-flight response and restarts at the target.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int               DEPTH    = 4,
   parameter int               XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   redirect,
   input  logic [XLEN-1:0]        redirect_pc,
   output logic                   imem_req,
   output logic [XLEN-1:0]        imem_addr,
   input  logic                   imem_gnt,
   input  logic                   imem_rvalid,
   input  logic [XLEN-1:0]        imem_rdata,
   output logic                   d_valid,
   output logic [XLEN-1:0]        d_inst,
   output logic [XLEN-1:0]        d_pc,
   input  logic                   d_ready,
   output logic [$clog2(DEPTH):0] fq_count
);

   localparam int CW = $clog2(DEPTH) + 1;

   fq_state_e         state;
   fq_state_e         state_nxt;
   logic [XLEN-1:0]   fetch_pc;
   logic [XLEN-1:0]   req_pc;
   logic              full;
   logic              fire;
   logic              push;
   logic              pop;
   logic [2*XLEN-1:0] head;
   logic              unused_redirect_lsb;

   // Target is always word aligned; the low bits carry no information.
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   assign full      = (fq_count == CW'(DEPTH));
   assign imem_addr = fetch_pc;
   assign fire      = imem_req & imem_gnt;
   assign d_valid   = (fq_count != '0) & ~redirect;
   assign pop       = d_valid & d_ready;

   // Sequencer next state, request strobe and push decision.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      state_nxt = state;
      imem_req  = 1'b0;
      push      = 1'b0;
      case (state)
         S_REQ: begin
            // rst term keeps the request low while reset is held.
            imem_req = rst & ~full & ~redirect;
            if (imem_req && imem_gnt) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               push      = ~redirect;
               state_nxt = S_REQ;
            end else if (redirect) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // The stale response is consumed whether or not another redirect arrives.
            if (imem_rvalid) state_nxt = S_REQ;
         end
         default: state_nxt = S_REQ;
      endcase
   end

   // State, fetch PC and in-flight request PC.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_REQ;
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
      end else begin
         state <= state_nxt;
         if (redirect) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
         end else if (fire) begin
            fetch_pc <= fetch_pc + XLEN'(4);
            req_pc   <= fetch_pc;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2*XLEN)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .wdata ({imem_rdata, req_pc + XLEN'(4)}),
      .head  (head),
      .count (fq_count)
   );

   // An empty queue presents a NOP rather than whatever the storage holds.
   assign d_inst = (fq_count != '0) ? head[2*XLEN-1:XLEN] : XLEN'(INST_NOP);
   assign d_pc   = head[XLEN-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a per-cycle vector table for the
// reset, stall and redirect corners, then an automatic memory model with a
// scoreboard for streaming and back-pressure.
module tb_fetch_queue;

   localparam bit H = 1'b1;
   localparam bit L = 1'b0;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        d_valid;
   logic [31:0] d_inst;
   logic [31:0] d_pc;
   logic        d_ready;
   logic [2:0]  fq_count;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_queue #(.DEPTH(4), .XLEN(32), .RESET_PC(32'h0)) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .d_valid     (d_valid),
      .d_inst      (d_inst),
      .d_pc        (d_pc),
      .d_ready     (d_ready),
      .fq_count    (fq_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        rst, gnt, rv;
      logic [31:0] rdata;
      logic        redir;
      logic [31:0] rpc;
      logic        rdy;
      logic        req;
      logic [31:0] addr;
      logic        dv;
      logic [31:0] inst;
      logic [31:0] pc;
      logic [2:0]  cnt;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t v(input logic r, g, rv, input logic [31:0] rd, input logic rdr,
                              input logic [31:0] rpc, input logic rdy, input logic req,
                              input logic [31:0] addr, input logic dv, input logic [31:0] inst,
                              input logic [31:0] pc, input logic [2:0] cnt);
      vec_t t;
      t = '{r, g, rv, rd, rdr, rpc, rdy, req, addr, dv, inst, pc, cnt};
      return t;
   endfunction

   task automatic apply_vec(input int i, input vec_t t);
      @(negedge clk);
      rst         = t.rst;
      imem_gnt    = t.gnt;
      imem_rvalid = t.rv;
      imem_rdata  = t.rdata;
      redirect    = t.redir;
      redirect_pc = t.rpc;
      d_ready     = t.rdy;
      #1;
      check($sformatf("v%0d imem_req", i),  32'(imem_req), 32'(t.req));
      check($sformatf("v%0d imem_addr", i), imem_addr,     t.addr);
      check($sformatf("v%0d d_valid", i),   32'(d_valid),  32'(t.dv));
      check($sformatf("v%0d fq_count", i),  32'(fq_count), 32'(t.cnt));
      if (t.dv) begin
         check($sformatf("v%0d d_inst", i), d_inst, t.inst);
         check($sformatf("v%0d d_pc", i),   d_pc,   t.pc);
      end
      @(posedge clk);
   endtask

   // ---------------- memory model + scoreboard ----------------
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } exp_t;

   exp_t        sb[$];
   int          pop_cyc[$];
   logic        pend;
   logic [31:0] pend_addr;
   logic [31:0] exp_addr;
   int          mcount;
   int          cyc;
   logic        gnt_en;
   logic        rdy_en;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h0031_8133 + a * 32'h0000_4040;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst         = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      redirect    = 1'b0;
      d_ready     = 1'b0;
      #1;
      check("reset imem_req", 32'(imem_req), 32'h0);
      check("reset fq_count", 32'(fq_count), 32'h0);
      @(negedge clk);
      rst       = 1'b1;
      pend      = 1'b0;
      pend_addr = '0;
      exp_addr  = '0;
      mcount    = 0;
      cyc       = 0;
      sb.delete();
      pop_cyc.delete();
      @(posedge clk);
   endtask

   task automatic mem_cycle();
      exp_t e;
      logic fired;
      @(negedge clk);
      imem_gnt    = gnt_en;
      imem_rvalid = pend;
      imem_rdata  = pend ? mem_word(pend_addr) : 32'h0;
      d_ready     = rdy_en;
      redirect    = 1'b0;
      #1;
      check("sb fq_count", 32'(fq_count), 32'(mcount));
      check("sb d_valid",  32'(d_valid),  32'(mcount != 0));
      if (d_valid && d_ready) begin
         check("sb entry available", 32'(sb.size() != 0), 32'h1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("sb d_inst", d_inst, e.inst);
            check("sb d_pc",   d_pc,   e.pc);
         end
         pop_cyc.push_back(cyc);
         mcount--;
      end
      if (imem_rvalid) mcount++;
      fired = imem_req & imem_gnt;
      if (fired) begin
         check("sb imem_addr", imem_addr, exp_addr);
         sb.push_back('{mem_word(imem_addr), imem_addr + 32'd4});
         exp_addr = exp_addr + 32'd4;
      end
      if (imem_rvalid) pend = 1'b0;
      if (fired) begin
         pend      = 1'b1;
         pend_addr = imem_addr;
      end
      cyc++;
      @(posedge clk);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst         = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      d_ready     = 1'b0;
      gnt_en      = 1'b0;
      rdy_en      = 1'b0;

      //           rst gnt rv rdata          rdr rpc       rdy  req addr      dv inst           pc        cnt
      // reset held, release, grant, reset again in S_WAIT, stale rvalid ignored
      vq.push_back(v(L, L, L, 32'h0,         L, 32'h0,   L,   L, 32'h0,   L, 32'h0,         32'h0,    3'd0));
      vq.push_back(v(H, H, L, 32'h0,         L, 32'h0,   L,   H, 32'h0,   L, 32'h0,         32'h0,    3'd0));
      vq.push_back(v(L, L, L, 32'h0,         L, 32'h0,   L,   L, 32'h0,   L, 32'h0,         32'h0,    3'd0));
      vq.push_back(v(H, L, H, 32'hDEADBEEF,  L, 32'h0,   L,   H, 32'h0,   L, 32'h0,         32'h0,    3'd0));
      vq.push_back(v(H, H, L, 32'h0,         L, 32'h0,   L,   H, 32'h0,   L, 32'h0,         32'h0,    3'd0));
      vq.push_back(v(H, L, H, 32'h00318133,  L, 32'h0,   L,   L, 32'h4,   L, 32'h0,         32'h0,    3'd0));
      vq.push_back(v(H, H, L, 32'h0,         L, 32'h0,   L,   H, 32'h4,   H, 32'h00318133,  32'h4,    3'd1));
      vq.push_back(v(H, L, H, 32'h00328233,  L, 32'h0,   L,   L, 32'h8,   H, 32'h00318133,  32'h4,    3'd1));
      // grant withheld three cycles at 0x8, then granted
      vq.push_back(v(H, L, L, 32'h0,         L, 32'h0,   L,   H, 32'h8,   H, 32'h00318133,  32'h4,    3'd2));
      vq.push_back(v(H, L, L, 32'h0,         L, 32'h0,   L,   H, 32'h8,   H, 32'h00318133,  32'h4,    3'd2));
      vq.push_back(v(H, L, L, 32'h0,         L, 32'h0,   L,   H, 32'h8,   H, 32'h00318133,  32'h4,    3'd2));
      vq.push_back(v(H, H, L, 32'h0,         L, 32'h0,   L,   H, 32'h8,   H, 32'h00318133,  32'h4,    3'd2));
      vq.push_back(v(H, L, L, 32'h0,         L, 32'h0,   L,   L, 32'hC,   H, 32'h00318133,  32'h4,    3'd2));
      // redirect to 0x43 while waiting on 0x8; stale data drained
      vq.push_back(v(H, L, L, 32'h0,         H, 32'h43,  L,   L, 32'hC,   L, 32'h0,         32'h0,    3'd2));
      vq.push_back(v(H, H, H, 32'h0BAD0BAD,  L, 32'h0,   L,   L, 32'h40,  L, 32'h0,         32'h0,    3'd0));
      vq.push_back(v(H, H, L, 32'h0,         L, 32'h0,   L,   H, 32'h40,  L, 32'h0,         32'h0,    3'd0));
      vq.push_back(v(H, L, H, 32'h00500093,  L, 32'h0,   L,   L, 32'h44,  L, 32'h0,         32'h0,    3'd0));
      vq.push_back(v(H, L, L, 32'h0,         L, 32'h0,   H,   H, 32'h44,  H, 32'h00500093,  32'h44,   3'd1));
      // fill to two entries, then redirect together with rvalid and d_ready
      vq.push_back(v(H, H, L, 32'h0,         L, 32'h0,   L,   H, 32'h44,  L, 32'h0,         32'h0,    3'd0));
      vq.push_back(v(H, L, H, 32'h11111111,  L, 32'h0,   L,   L, 32'h48,  L, 32'h0,         32'h0,    3'd0));
      vq.push_back(v(H, H, L, 32'h0,         L, 32'h0,   L,   H, 32'h48,  H, 32'h11111111,  32'h48,   3'd1));
      vq.push_back(v(H, L, H, 32'h22222222,  L, 32'h0,   L,   L, 32'h4C,  H, 32'h11111111,  32'h48,   3'd1));
      vq.push_back(v(H, H, L, 32'h0,         L, 32'h0,   L,   H, 32'h4C,  H, 32'h11111111,  32'h48,   3'd2));
      vq.push_back(v(H, L, H, 32'h33333333,  H, 32'h100, H,   L, 32'h50,  L, 32'h0,         32'h0,    3'd2));
      vq.push_back(v(H, L, L, 32'h0,         L, 32'h0,   H,   H, 32'h100, L, 32'h0,         32'h0,    3'd0));
      vq.push_back(v(H, H, L, 32'h0,         L, 32'h0,   H,   H, 32'h100, L, 32'h0,         32'h0,    3'd0));
      vq.push_back(v(H, L, H, 32'h44444444,  L, 32'h0,   H,   L, 32'h104, L, 32'h0,         32'h0,    3'd0));
      vq.push_back(v(H, L, L, 32'h0,         L, 32'h0,   H,   H, 32'h104, H, 32'h44444444,  32'h104,  3'd1));

      for (int i = 0; i < vq.size(); i++) apply_vec(i, vq[i]);

      // Zero-wait streaming: one instruction every two cycles.
      do_reset();
      gnt_en = 1'b1;
      rdy_en = 1'b1;
      for (int i = 0; i < 10; i++) mem_cycle();
      check("stream pop count", 32'(pop_cyc.size()), 32'd4);
      if (pop_cyc.size() >= 2) begin
         check("stream first pop cycle", 32'(pop_cyc[0]), 32'd2);
         check("stream pop spacing", 32'(pop_cyc[1] - pop_cyc[0]), 32'd2);
      end

      // Back-pressure: queue fills, requests stop, resume at 0x10.
      do_reset();
      gnt_en = 1'b1;
      rdy_en = 1'b0;
      for (int i = 0; i < 12; i++) mem_cycle();
      #1;
      check("full fq_count", 32'(fq_count), 32'd4);
      check("full imem_req", 32'(imem_req), 32'h0);
      check("full d_valid",  32'(d_valid),  32'h1);
      check("full head d_pc", d_pc, 32'h4);
      rdy_en = 1'b1;
      mem_cycle();
      #1;
      check("resume imem_req",  32'(imem_req), 32'h1);
      check("resume imem_addr", imem_addr,     32'h10);
      for (int i = 0; i < 16; i++) mem_cycle();
      gnt_en = 1'b0;
      for (int i = 0; i < 10; i++) mem_cycle();
      check("drain scoreboard empty", 32'(sb.size()), 32'h0);
      check("drain fq_count", 32'(fq_count), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction prefetch stage that sits between the instruction memory and the F->D pipe register.
- Owns the fetch PC.
- Issues word requests to the instruction memory over a req/gnt/rvalid handshake, with at most one request in flight.
- Buffers returned instructions, each tagged with its pc+4, in a small FIFO.
- Presents them to decode with valid/ready.
- A taken-branch redirect flushes the queue, squashes any in-flight response and restarts fetch at the target.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
XLEN, 32, address and instruction width
RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
redirect  in  1  taken branch from the memory stage (branch & zero)
redirect_pc  in  XLEN  branch target; bits [1:0] ignored and treated as 0
imem_req  out  1  request valid
imem_addr  out  XLEN  word-aligned request address
imem_gnt  in  1  memory accepts the request this cycle
imem_rvalid  in  1  response valid; never in the same cycle as its grant
imem_rdata  in  XLEN  returned instruction
d_valid  out  1  head entry valid
d_inst  out  XLEN  head instruction
d_pc  out  XLEN  head instruction address + 4
d_ready  in  1  decode accepts the head entry
fq_count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst low, asynchronous) state:
  - fetch_pc = RESET_PC, FIFO empty, state = S_REQ.
  - imem_req = 0, d_valid = 0, fq_count = 0.
  - imem_req is forced 0 while rst is low.
  - A reset mid-transaction abandons the outstanding response.
- FSM states: S_REQ, S_WAIT, S_DRAIN.
- S_REQ:
  - imem_req = (fq_count < DEPTH) & ~redirect.
  - imem_addr = fetch_pc.
  - On imem_req & imem_gnt: latch req_pc = fetch_pc, set fetch_pc += 4, go to S_WAIT.
  - Without a grant, imem_req and imem_addr hold stable.
- S_WAIT:
  - imem_req = 0.
  - On imem_rvalid: push {imem_rdata, req_pc+4} and go to S_REQ.
- S_DRAIN:
  - imem_req = 0.
  - On imem_rvalid: discard the data and go to S_REQ.
- Redirect (highest priority, any state):
  - FIFO flushed: fq_count = 0 next cycle, no pop, no push that cycle.
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - S_WAIT without rvalid -> S_DRAIN.
  - S_WAIT with rvalid the same cycle -> response dropped, go to S_REQ.
  - In S_DRAIN: stay in S_DRAIN.
  - In S_REQ: stay in S_REQ (request suppressed).
- Output side:
  - d_valid = (fq_count != 0) & ~redirect.
  - d_inst and d_pc come from the head entry, registered storage only; no bypass from imem_rdata.
  - Pop occurs on d_valid & d_ready.
- Count update: push and pop in the same cycle leave fq_count unchanged. Pop when empty is impossible because d_valid = 0.
- Overflow cannot occur: a request is only issued when fq_count < DEPTH, and pops only reduce occupancy.
- Latency:
  - Grant at cycle t, rvalid at t+1 at the earliest, entry visible on d_valid at t+2.
  - Next request at t+2 at the earliest, so peak throughput is 1 instruction per 2 cycles.
- FIFO pointers wrap modulo DEPTH.
- fetch_pc wraps modulo 2^XLEN.

Decomposition:
- Package fetch_pkg:
  - typedef fq_state_e {S_REQ, S_WAIT, S_DRAIN}
  - localparam XLEN_DEF = 32
  - localparam INST_NOP = 32'h0000_0013
- Sub-module fetch_fifo:
  - Synchronous FIFO, width 2*XLEN, depth DEPTH.
  - Ports: push, pop, flush, count, head data.
  - Flush has priority over push and pop.
  - Same clock and asynchronous active-low reset as the parent.

Test Plan:
1. Assert rst low during S_WAIT -> imem_req = 0, d_valid = 0, fq_count = 0 immediately. After release, the first imem_addr is 0 and the stale rvalid is ignored.
2. Zero-wait memory (gnt=1, rvalid one cycle later), d_ready = 1, memory returns 0x00318133 then 0x00328233 -> decode sees d_inst 0x00318133 with d_pc 4, then 0x00328233 with d_pc 8, spaced 2 cycles apart.
3. d_ready = 0 for 12 cycles -> fq_count reaches 4 and imem_req stays 0. Raise d_ready -> head d_pc = 4, and fetch resumes at imem_addr 0x10.
4. Redirect to 0x43 while in S_WAIT for address 0x8 -> the rvalid for 0x8 is discarded in S_DRAIN, the next imem_addr is 0x40, and the first entry delivered has d_pc = 0x44.
5. Redirect in the same cycle as rvalid and d_ready with fq_count = 2 -> no push, no pop. Next cycle fq_count = 0, d_valid = 0, and the next request is to redirect_pc.
6. imem_gnt held low for 3 cycles in S_REQ at address 0x8 -> imem_req = 1 and imem_addr = 0x8 stay stable; the grant on the fourth cycle moves to S_WAIT.
